// File: rtl/stage_decode_if.sv
// Fetch/writeback-to-decode bundle: fetched instruction, register-file write port and the
// registered decode results handed on to execute.
interface stage_decode_if #(
    parameter int unsigned INSTR_SIZE = 32
);
    logic [INSTR_SIZE-1:0] pc_i;
    logic [INSTR_SIZE-1:0] instr_i;
    logic                  flush_i;
    logic                  wb_en_i;
    logic [4:0]            wb_addr_i;
    logic [INSTR_SIZE-1:0] wb_data_i;

    logic                  stall_o;
    logic [INSTR_SIZE-1:0] pc_o;
    logic [INSTR_SIZE-1:0] rs1_data_o;
    logic [INSTR_SIZE-1:0] rs2_data_o;
    logic [INSTR_SIZE-1:0] imm_o;
    logic [4:0]            rd_o;
    logic [3:0]            alu_op_o;
    logic                  valid_o;
    logic                  reg_wr_o;
    logic                  mem_rd_o;
    logic                  mem_wr_o;
    logic                  branch_o;
    logic                  jump_o;
    logic                  alu_imm_o;
    logic                  illegal_o;

    modport master (
        output pc_i, instr_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        input  stall_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, alu_op_o,
        input  valid_o, reg_wr_o, mem_rd_o, mem_wr_o, branch_o, jump_o, alu_imm_o, illegal_o
    );

    modport slave (
        input  pc_i, instr_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        output stall_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, alu_op_o,
        output valid_o, reg_wr_o, mem_rd_o, mem_wr_o, branch_o, jump_o, alu_imm_o, illegal_o
    );
endinterface

// File: rtl/stage_decode.sv
// RV32I decode stage: register file with write-through bypass, immediate/control decode,
// one-cycle load-use stall and flush handling, all outputs registered.
module stage_decode #(
    parameter int unsigned           INSTR_SIZE = 32,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [INSTR_SIZE-1:0] BOOT_ADDR  = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset_n,
    stage_decode_if.slave dec
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] pc;
        logic [INSTR_SIZE-1:0] rs1;
        logic [INSTR_SIZE-1:0] rs2;
        logic [INSTR_SIZE-1:0] imm;
        logic [4:0]            rd;
        logic [3:0]            alu_op;
        logic                  valid;
        logic                  reg_wr;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  branch;
        logic                  jump;
        logic                  alu_imm;
        logic                  illegal;
    } dec_out_t;

    dec_out_t              out_q, out_d;
    logic [INSTR_SIZE-1:0] regs_q [32];
    logic [INSTR_SIZE-1:0] regs_d [32];

    logic [4:0]            rs1_addr, rs2_addr;
    logic [INSTR_SIZE-1:0] rs1_val, rs2_val;
    logic [6:0]            fetch_opc;
    logic                  use_rs1, use_rs2;
    logic                  stall, kill;

    logic [INSTR_SIZE-1:0] instr_dec;
    logic [6:0]            opc;
    logic [2:0]            funct3;
    logic                  funct7_b5;
    logic [INSTR_SIZE-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic                  dec_legal, dec_reg_type, dec_mem_rd, dec_mem_wr;
    logic                  dec_branch, dec_jump, dec_alu_imm;
    logic [INSTR_SIZE-1:0] dec_imm;
    logic [4:0]            dec_rd;
    logic [3:0]            dec_alu_op;

    // Register file; x0 is never stored and a write during reset is dropped.
    always_comb begin
        regs_d = regs_q;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = '0;
            end
        end else if (dec.wb_en_i && (dec.wb_addr_i != 5'd0)) begin
            regs_d[dec.wb_addr_i] = dec.wb_data_i;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign rs1_addr = dec.instr_i[19:15];
    assign rs2_addr = dec.instr_i[24:20];

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_addr != 5'd0) begin
            rs1_val = (dec.wb_en_i && (dec.wb_addr_i == rs1_addr)) ? dec.wb_data_i
                                                                    : regs_q[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            rs2_val = (dec.wb_en_i && (dec.wb_addr_i == rs2_addr)) ? dec.wb_data_i
                                                                    : regs_q[rs2_addr];
        end
    end

    // Load-use hazard against the instruction currently waiting in fetch.
    always_comb begin
        fetch_opc = dec.instr_i[6:0];
        use_rs1   = !((fetch_opc == OpcLui) || (fetch_opc == OpcAuipc) || (fetch_opc == OpcJal));
        use_rs2   = (fetch_opc == OpcOp) || (fetch_opc == OpcStore) || (fetch_opc == OpcBranch);
        stall     = !dec.flush_i && out_q.valid && out_q.mem_rd && (out_q.rd != 5'd0) &&
                    ((use_rs1 && (rs1_addr == out_q.rd)) || (use_rs2 && (rs2_addr == out_q.rd)));
        kill      = dec.flush_i || stall;
    end

    // The decoder sees the canonical nop while killing so its datapath stays quiet.
    assign instr_dec = kill ? NOP_INSTR : dec.instr_i;
    assign opc       = instr_dec[6:0];
    assign funct3    = instr_dec[14:12];

    assign imm_i = {{(INSTR_SIZE-12){instr_dec[31]}}, instr_dec[31:20]};
    assign imm_s = {{(INSTR_SIZE-12){instr_dec[31]}}, instr_dec[31:25], instr_dec[11:7]};
    assign imm_b = {{(INSTR_SIZE-13){instr_dec[31]}}, instr_dec[31], instr_dec[7],
                    instr_dec[30:25], instr_dec[11:8], 1'b0};
    assign imm_u = {instr_dec[31:12], 12'b0};
    assign imm_j = {{(INSTR_SIZE-21){instr_dec[31]}}, instr_dec[31], instr_dec[19:12],
                    instr_dec[20], instr_dec[30:21], 1'b0};

    always_comb begin
        dec_legal    = 1'b1;
        dec_reg_type = 1'b0;
        dec_mem_rd   = 1'b0;
        dec_mem_wr   = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_alu_imm  = 1'b1;
        dec_imm      = '0;
        unique case (opc)
            OpcOp: begin
                dec_reg_type = 1'b1;
                dec_alu_imm  = 1'b0;
            end
            OpcOpImm: begin
                dec_reg_type = 1'b1;
                dec_imm      = imm_i;
            end
            OpcLoad: begin
                dec_reg_type = 1'b1;
                dec_mem_rd   = 1'b1;
                dec_imm      = imm_i;
            end
            OpcStore: begin
                dec_mem_wr = 1'b1;
                dec_imm    = imm_s;
            end
            OpcBranch: begin
                dec_branch  = 1'b1;
                dec_alu_imm = 1'b0;
                dec_imm     = imm_b;
            end
            OpcJal: begin
                dec_reg_type = 1'b1;
                dec_jump     = 1'b1;
                dec_imm      = imm_j;
            end
            OpcJalr: begin
                dec_reg_type = 1'b1;
                dec_jump     = 1'b1;
                dec_imm      = imm_i;
            end
            OpcLui, OpcAuipc: begin
                dec_reg_type = 1'b1;
                dec_imm      = imm_u;
            end
            default: begin
                dec_legal   = 1'b0;
                dec_alu_imm = 1'b0;
            end
        endcase
    end

    // Only shifts carry funct7[5] among the immediate ALU ops.
    assign funct7_b5  = instr_dec[30] &&
                        !((opc == OpcOpImm) && (funct3[1:0] != 2'b01));
    assign dec_alu_op = dec_legal ? {funct7_b5, funct3} : 4'd0;
    assign dec_rd     = dec_reg_type ? instr_dec[11:7] : 5'd0;

    always_comb begin
        out_d = out_q;
        if (!reset_n) begin
            out_d    = '0;
            out_d.pc = BOOT_ADDR;
        end else if (kill) begin
            out_d.imm     = '0;
            out_d.rd      = 5'd0;
            out_d.alu_op  = 4'd0;
            out_d.valid   = 1'b0;
            out_d.reg_wr  = 1'b0;
            out_d.mem_rd  = 1'b0;
            out_d.mem_wr  = 1'b0;
            out_d.branch  = 1'b0;
            out_d.jump    = 1'b0;
            out_d.alu_imm = 1'b0;
            out_d.illegal = 1'b0;
        end else begin
            out_d.pc      = dec.pc_i;
            out_d.rs1     = rs1_val;
            out_d.rs2     = rs2_val;
            out_d.imm     = dec_imm;
            out_d.rd      = dec_rd;
            out_d.alu_op  = dec_alu_op;
            out_d.valid   = 1'b1;
            out_d.reg_wr  = dec_reg_type && (dec_rd != 5'd0);
            out_d.mem_rd  = dec_mem_rd;
            out_d.mem_wr  = dec_mem_wr;
            out_d.branch  = dec_branch;
            out_d.jump    = dec_jump;
            out_d.alu_imm = dec_alu_imm;
            out_d.illegal = !dec_legal;
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign dec.stall_o    = stall;
    assign dec.pc_o       = out_q.pc;
    assign dec.rs1_data_o = out_q.rs1;
    assign dec.rs2_data_o = out_q.rs2;
    assign dec.imm_o      = out_q.imm;
    assign dec.rd_o       = out_q.rd;
    assign dec.alu_op_o   = out_q.alu_op;
    assign dec.valid_o    = out_q.valid;
    assign dec.reg_wr_o   = out_q.reg_wr;
    assign dec.mem_rd_o   = out_q.mem_rd;
    assign dec.mem_wr_o   = out_q.mem_wr;
    assign dec.branch_o   = out_q.branch;
    assign dec.jump_o     = out_q.jump;
    assign dec.alu_imm_o  = out_q.alu_imm;
    assign dec.illegal_o  = out_q.illegal;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed vector table, hand-written stall/reset sequences, then
// random traffic checked against a behavioural model of the decode rules.
module tb_stage_decode;

    localparam logic [31:0] BootA = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        valid;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        alu_imm;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    stage_decode_if #(.INSTR_SIZE(32)) bus ();

    stage_decode #(
        .INSTR_SIZE(32),
        .NOP_INSTR (32'h0000_0013),
        .BOOT_ADDR (BootA)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .dec    (bus)
    );

    function automatic obs_t mk(input logic [31:0] pc, r1, r2, im, input logic [4:0] rd,
                                input logic [3:0] aop, input logic [7:0] ctrl);
        obs_t o;
        o.pc = pc;
        o.rs1 = r1;
        o.rs2 = r2;
        o.imm = im;
        o.rd = rd;
        o.alu_op = aop;
        {o.valid, o.reg_wr, o.mem_rd, o.mem_wr, o.branch, o.jump, o.alu_imm, o.illegal} = ctrl;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.pc_o, bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.rd_o, bus.alu_op_o,
                  {bus.valid_o, bus.reg_wr_o, bus.mem_rd_o, bus.mem_wr_o, bus.branch_o,
                   bus.jump_o, bus.alu_imm_o, bus.illegal_o});
    endfunction

    task automatic chk_out(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: outputs got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        n_vec++;
        if (bus.stall_o !== exp) begin
            n_err++;
            $display("FAIL %s: stall_o got %b, expected %b", name, bus.stall_o, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, ins, input logic fl, we,
                         input logic [4:0] wa, input logic [31:0] wd);
        bus.pc_i      = pc;
        bus.instr_i   = ins;
        bus.flush_i   = fl;
        bus.wb_en_i   = we;
        bus.wb_addr_i = wa;
        bus.wb_data_i = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mrf [32];
    obs_t        mexp;

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return mrf[a];
    endfunction

    function automatic obs_t ref_decode(input logic [31:0] ins, pc, a, b);
        obs_t o;
        logic writes;
        logic [31:0] im;
        logic [2:0] f3;
        logic shift;
        o = '0;
        writes = 1'b0;
        im = 32'd0;
        f3 = ins[14:12];
        shift = (f3 == 3'b001) || (f3 == 3'b101);
        o.pc = pc;
        o.rs1 = a;
        o.rs2 = b;
        o.valid = 1'b1;
        o.alu_imm = 1'b1;
        case (ins[6:0])
            7'b0110011: begin writes = 1'b1; o.alu_imm = 1'b0; end
            7'b0010011: begin writes = 1'b1; im = 32'($signed(ins[31:20])); end
            7'b0000011: begin writes = 1'b1; o.mem_rd = 1'b1; im = 32'($signed(ins[31:20])); end
            7'b0100011: begin o.mem_wr = 1'b1; im = 32'($signed({ins[31:25], ins[11:7]})); end
            7'b1100011: begin
                o.branch = 1'b1;
                o.alu_imm = 1'b0;
                im = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'b1101111: begin
                writes = 1'b1;
                o.jump = 1'b1;
                im = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'b1100111: begin writes = 1'b1; o.jump = 1'b1; im = 32'($signed(ins[31:20])); end
            7'b0110111, 7'b0010111: begin writes = 1'b1; im = ins & 32'hFFFF_F000; end
            default: begin o.illegal = 1'b1; o.alu_imm = 1'b0; end
        endcase
        o.imm = im;
        if (!o.illegal) begin
            o.alu_op = {ins[30] && !(ins[6:0] == 7'b0010011 && !shift), f3};
        end
        o.rd = writes ? ins[11:7] : 5'd0;
        o.reg_wr = writes && (ins[11:7] != 5'd0);
        return o;
    endfunction

    function automatic logic ref_stall(input logic [31:0] ins, input logic fl);
        logic [6:0] op;
        logic u1, u2;
        op = ins[6:0];
        u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return !fl && mexp.valid && mexp.mem_rd && (mexp.rd != 5'd0) &&
               ((u1 && ins[19:15] == mexp.rd) || (u2 && ins[24:20] == mexp.rd));
    endfunction

    vec_t tbl [11];
    logic [6:0] opcs [10];

    initial begin
        logic [31:0] pc, ins, wd, r1, r2;
        logic fl, we, rst, mst;
        logic [4:0] wa;
        logic [6:0] op;

        tbl[0]  = '{32'h100, 32'h0000_0013, 1'b0, 1'b1, 5'd5, 32'hAA,
                    mk(32'h100, 0, 0, 0, 0, 0, 8'b1000_0010)};
        tbl[1]  = '{32'h104, 32'h0052_8333, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h104, 32'hAA, 32'hAA, 0, 6, 0, 8'b1100_0000)};
        tbl[2]  = '{32'h108, 32'hFFF3_8413, 1'b0, 1'b1, 5'd7, 32'h1234,
                    mk(32'h108, 32'h1234, 0, 32'hFFFF_FFFF, 8, 0, 8'b1100_0010)};
        tbl[3]  = '{32'h10C, 32'h0080_00EF, 1'b1, 1'b0, 5'd0, 32'h0,
                    mk(32'h108, 32'h1234, 0, 0, 0, 0, 8'b0000_0000)};
        tbl[4]  = '{32'h110, 32'h0050_0093, 1'b0, 1'b1, 5'd0, 32'hFFFF,
                    mk(32'h110, 0, 32'hAA, 5, 1, 0, 8'b1100_0010)};
        tbl[5]  = '{32'h114, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h114, 0, 0, 0, 0, 0, 8'b1000_0001)};
        tbl[6]  = '{32'h118, 32'h0080_00EF, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h118, 0, 0, 8, 1, 0, 8'b1100_0110)};
        tbl[7]  = '{32'h11C, 32'h0062_A223, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h11C, 32'hAA, 0, 4, 0, 4'h2, 8'b1001_0010)};
        tbl[8]  = '{32'h120, 32'h4030_D113, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h120, 0, 0, 32'h403, 2, 4'hD, 8'b1100_0010)};
        tbl[9]  = '{32'h124, 32'hFE62_8EE3, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h124, 32'hAA, 0, 32'hFFFF_FFFC, 0, 4'h8, 8'b1000_1000)};
        tbl[10] = '{32'h128, 32'h1234_51B7, 1'b0, 1'b0, 5'd0, 32'h0,
                    mk(32'h128, 0, 0, 32'h1234_5000, 3, 4'h5, 8'b1100_0010)};

        // Reset
        drive(32'h0, 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
        reset_n = 1'b0;
        tick();
        tick();
        chk_out("reset", mk(BootA, 0, 0, 0, 0, 0, 8'b0));
        chk_stall("reset_stall", 1'b0);
        reset_n = 1'b1;

        // Directed table
        foreach (tbl[i]) begin
            drive(tbl[i].pc, tbl[i].instr, tbl[i].flush, tbl[i].wb_en, tbl[i].wb_addr,
                  tbl[i].wb_data);
            #1;
            chk_stall($sformatf("tbl%0d_stall", i), 1'b0);
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // Load-use: lw x9,0(x1) then add x10,x9,x2
        drive(32'h200, 32'h0000_A483, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_out("lu_load", mk(32'h200, 0, 0, 0, 9, 4'h2, 8'b1110_0010));
        drive(32'h204, 32'h0024_8533, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk_stall("lu_stall_hi", 1'b1);
        tick();
        chk_out("lu_bubble", mk(32'h200, 0, 0, 0, 0, 0, 8'b0));
        drive(32'h204, 32'h0024_8533, 1'b0, 1'b1, 5'd2, 32'h55);
        #1;
        chk_stall("lu_stall_lo", 1'b0);
        tick();
        chk_out("lu_add", mk(32'h204, 0, 32'h55, 0, 10, 0, 8'b1100_0000));

        // Reset during a stall, with a coincident write that must be dropped
        drive(32'h300, 32'h0000_A483, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(32'h304, 32'h0024_8533, 1'b0, 1'b1, 5'd5, 32'h77);
        #1;
        chk_stall("rs_stall_hi", 1'b1);
        reset_n = 1'b0;
        tick();
        chk_out("rs_reset", mk(BootA, 0, 0, 0, 0, 0, 8'b0));
        chk_stall("rs_stall_lo", 1'b0);
        reset_n = 1'b1;
        drive(32'h308, 32'h0052_8333, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_out("rs_first", mk(32'h308, 0, 0, 0, 6, 0, 8'b1100_0000));

        // Random traffic against the model
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset_n = 1'b0;
        drive(32'h0, 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        mexp = mk(BootA, 0, 0, 0, 0, 0, 8'b0);
        foreach (mrf[i]) mrf[i] = 32'd0;
        mst = 1'b0;
        pc = 32'h400;
        ins = 32'h13;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            we  = $urandom_range(0, 1) == 1;
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            if (!mst) begin
                pc = pc + 32'd4;
                if ($urandom_range(0, 15) == 0) begin
                    op = ($urandom_range(0, 1) == 1) ? 7'b1111111 : 7'b0001011;
                end else begin
                    op = opcs[$urandom_range(0, 9)];
                end
                ins = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       3'($urandom), 5'($urandom_range(0, 7)), op};
            end
            reset_n = rst;
            drive(pc, ins, fl, we, wa, wd);
            #1;
            mst = ref_stall(ins, fl);
            chk_stall("rand_stall", mst);
            if (!rst) begin
                mexp = mk(BootA, 0, 0, 0, 0, 0, 8'b0);
                foreach (mrf[i]) mrf[i] = 32'd0;
            end else begin
                r1 = mread(ins[19:15], we, wa, wd);
                r2 = mread(ins[24:20], we, wa, wd);
                if (fl || mst) begin
                    mexp = mk(mexp.pc, mexp.rs1, mexp.rs2, 0, 0, 0, 8'b0);
                end else begin
                    mexp = ref_decode(ins, pc, r1, r2);
                end
                if (we && wa != 5'd0) mrf[wa] = wd;
            end
            tick();
            chk_out("rand", mexp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
